sram_reader: RTL and testbench

SRAM_READER -- requirements
Module: sram_reader

---
 rtl/nn_mem_pkg.sv | 24 ++
 rtl/sram_reader.sv | 147 ++++++++++++++
 tb/tb_sram_reader.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_mem_pkg.sv
// Shared definitions for the neural-network memory path: the reader FSM state
// type and the default frame geometry, also used by the SRAM write controller.
package nn_mem_pkg;

  // One 28x28 image of 8-bit pixels, stored in a 1K-word SRAM.
  localparam int NUM_WORDS_DEF = 784;
  localparam int ADDR_W_DEF    = 10;
  localparam int DATA_W_DEF    = 8;
  localparam int RD_LAT_DEF    = 2;

  // Wide enough for the largest supported read latency (7).
  localparam int LAT_CNT_W = 3;

  localparam int CHECKSUM_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    PRESENT,
    DONE
  } rd_state_e;

endpackage

// File: rtl/sram_reader.sv
// Streams one frame of NUM_WORDS pixels out of a fixed-latency SRAM, one
// word at a time, over a valid/ready pixel interface.
// Optional build macro SRAM_READER_CHECKSUM_EN adds a 16-bit running sum of
// the accepted pixels on the checksum output.
module sram_reader
  import nn_mem_pkg::*;
#(
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RD_LAT    = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_rden,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic              busy,
  output logic              done
`ifdef SRAM_READER_CHECKSUM_EN
  ,
  output logic [CHECKSUM_W-1:0] checksum
`endif
);

  localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD  = LAT_CNT_W'(RD_LAT);

  rd_state_e            state;
  logic [LAT_CNT_W-1:0] lat_cnt;

  logic handshake;
  logic cancel;

  assign handshake = (state == PRESENT) && pix_ready;
  // Abort only means something while a frame is in flight.
  assign cancel    = abort && (state != IDLE);

  // Frame sequencer: address/latency counters and all registered outputs.
  // NOTE: reset is asynchronous (listed in the sensitivity list) and every
  // state register uses <= so all of them update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      sram_addr <= '0;
      sram_rden <= 1'b0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (cancel) begin
      // Cancel wins over a same-cycle handshake; the frame is dropped silently.
      state     <= IDLE;
      lat_cnt   <= '0;
      sram_addr <= '0;
      sram_rden <= 1'b0;
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            sram_addr <= '0;
            sram_rden <= 1'b1;
            busy      <= 1'b1;
          end
        end

        ISSUE: begin
          state     <= WAIT_RD;
          sram_rden <= 1'b0;
          lat_cnt   <= LAT_LOAD;
        end

        WAIT_RD: begin
          if (lat_cnt == LAT_CNT_W'(1)) begin
            state     <= PRESENT;
            lat_cnt   <= '0;
            pix_data  <= sram_rdata;
            pix_valid <= 1'b1;
            pix_last  <= (sram_addr == LAST_ADDR);
          end else begin
            lat_cnt <= lat_cnt - LAT_CNT_W'(1);
          end
        end

        PRESENT: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            if (sram_addr == LAST_ADDR) begin
              // Address stays on the last word; it is cleared on the way out.
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= ISSUE;
              sram_addr <= sram_addr + ADDR_W'(1);
              sram_rden <= 1'b1;
            end
          end
        end

        DONE: begin
          state     <= IDLE;
          sram_addr <= '0;
          done      <= 1'b0;
          busy      <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          sram_addr <= '0;
          sram_rden <= 1'b0;
          pix_valid <= 1'b0;
          pix_last  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

`ifdef SRAM_READER_CHECKSUM_EN
  // Running modulo-2^16 sum of accepted pixels; holds after DONE until the next start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if (cancel || ((state == IDLE) && start)) begin
      checksum <= '0;
    end else if (handshake) begin
      checksum <= checksum + CHECKSUM_W'(pix_data);
    end
  end
`endif

endmodule

// File: tb/tb_sram_reader.sv
// Self-checking bench for sram_reader: a cycle table for the start of a frame,
// then hand-written sequences for a full frame, back-pressure, abort, restart
// and asynchronous reset. Define SRAM_READER_CHECKSUM_EN to also check checksum.
module tb_sram_reader;

  localparam int NUM_WORDS = 784;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 8;
  localparam int RD_LAT    = 2;
  localparam int BUDGET    = 4000;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              abort;
  logic              pix_ready;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_rden;
  logic [DATA_W-1:0] sram_rdata;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_last;
  logic              busy;
  logic              done;
`ifdef SRAM_READER_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];

  always #5 clk = ~clk;

  // SRAM model: data for an address strobed with sram_rden appears RD_LAT
  // cycles later; a cycle without a strobe pushes a poison byte instead.
  always @(posedge clk) begin
    rd_pipe[0] <= sram_rden ? mem[sram_addr] : 8'hEE;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign sram_rdata = rd_pipe[RD_LAT-1];

  sram_reader #(
    .NUM_WORDS(NUM_WORDS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RD_LAT   (RD_LAT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .sram_addr (sram_addr),
    .sram_rden (sram_rden),
    .sram_rdata(sram_rdata),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_last  (pix_last),
    .busy      (busy),
    .done      (done)
`ifdef SRAM_READER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  typedef struct {
    logic              start;
    logic              abort;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic              rden;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              last;
    logic              busy;
    logic              done;
  } vec_t;

  localparam int N_VEC = 13;
  vec_t vecs [N_VEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    pix_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},      32'(busy),      32'd0);
    check({tag, ".pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, ".sram_rden"}, 32'(sram_rden), 32'd0);
    check({tag, ".sram_addr"}, 32'(sram_addr), 32'd0);
    check({tag, ".done"},      32'(done),      32'd0);
  endtask

  function automatic vec_t mk(input logic st, ab, rd, input int addr, input logic rden,
                              valid, input int data, input logic last, bsy, dn);
    vec_t v;
    v.start = st;   v.abort = ab;   v.ready = rd;
    v.addr  = ADDR_W'(addr);
    v.rden  = rden; v.valid = valid;
    v.data  = DATA_W'(data);
    v.last  = last; v.busy  = bsy;  v.done  = dn;
    return v;
  endfunction

  // Wait for PRESENT on word a (want_present) or WAIT_RD on word a, with pix_ready high.
  task automatic wait_state(input int a, input bit want_present, input string tag);
    int n = 0;
    pix_ready = 1'b1;
    while (n < BUDGET) begin
      if (want_present && pix_valid && sram_addr == ADDR_W'(a)) break;
      if (!want_present && busy && !pix_valid && !sram_rden && sram_addr == ADDR_W'(a)) break;
      tick();
      n++;
    end
    check({tag, ".reached"}, 32'(n < BUDGET), 32'd1);
  endtask

  initial begin
    int k, first_valid, n_pix, bad_pix, last_cnt, last_idx, done_cnt, done_edge, bad;
    bit done_seen;

    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'(i);

    //            st ab rd  addr rden vld data last busy done
    vecs[0]  = mk(1, 0, 1,  0,   1,   0,  0,   0,   1,   0); // start -> ISSUE
    vecs[1]  = mk(0, 0, 1,  0,   0,   0,  0,   0,   1,   0); // WAIT_RD 1
    vecs[2]  = mk(0, 0, 1,  0,   0,   0,  0,   0,   1,   0); // WAIT_RD 2
    vecs[3]  = mk(0, 0, 1,  0,   0,   1,  0,   0,   1,   0); // PRESENT word 0
    vecs[4]  = mk(0, 0, 1,  1,   1,   0,  0,   0,   1,   0); // handshake -> ISSUE word 1
    vecs[5]  = mk(1, 0, 1,  1,   0,   0,  0,   0,   1,   0); // start while busy ignored
    vecs[6]  = mk(0, 0, 1,  1,   0,   0,  0,   0,   1,   0);
    vecs[7]  = mk(0, 0, 0,  1,   0,   1,  1,   0,   1,   0); // PRESENT word 1
    vecs[8]  = mk(0, 0, 0,  1,   0,   1,  1,   0,   1,   0); // ready low: hold
    vecs[9]  = mk(0, 0, 0,  1,   0,   1,  1,   0,   1,   0);
    vecs[10] = mk(0, 0, 1,  2,   1,   0,  0,   0,   1,   0); // handshake -> ISSUE word 2
    vecs[11] = mk(0, 1, 0,  0,   0,   0,  0,   0,   0,   0); // abort in ISSUE
    vecs[12] = mk(0, 0, 1,  0,   0,   0,  0,   0,   0,   0); // stays idle, no done

    // Reset state and the cycle table.
    do_reset();
    check_idle("reset");
    check("reset.pix_data", 32'(pix_data), 32'd0);
    check("reset.pix_last", 32'(pix_last), 32'd0);

    for (int i = 0; i < N_VEC; i++) begin
      start     = vecs[i].start;
      abort     = vecs[i].abort;
      pix_ready = vecs[i].ready;
      tick();
      check($sformatf("vec%0d.sram_addr", i), 32'(sram_addr), 32'(vecs[i].addr));
      check($sformatf("vec%0d.sram_rden", i), 32'(sram_rden), 32'(vecs[i].rden));
      check($sformatf("vec%0d.pix_valid", i), 32'(pix_valid), 32'(vecs[i].valid));
      check($sformatf("vec%0d.pix_last",  i), 32'(pix_last),  32'(vecs[i].last));
      check($sformatf("vec%0d.busy",      i), 32'(busy),      32'(vecs[i].busy));
      check($sformatf("vec%0d.done",      i), 32'(done),      32'(vecs[i].done));
      if (vecs[i].valid)
        check($sformatf("vec%0d.pix_data", i), 32'(pix_data), 32'(vecs[i].data));
    end
    start = 1'b0;
    abort = 1'b0;

    // Full frame with pix_ready held high; k counts edges after the start edge.
    do_reset();
    first_valid = -1; n_pix = 0; bad_pix = 0; last_cnt = 0; last_idx = -1;
    done_cnt = 0; done_edge = -1; done_seen = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (k < BUDGET) begin
      if (pix_valid && first_valid < 0) first_valid = k + 1;
      if (pix_last) begin
        last_cnt++;
        last_idx = n_pix;
      end
      if (pix_valid) begin
        if (pix_data !== DATA_W'(n_pix)) bad_pix++;
        n_pix++;
      end
      if (done) begin
        done_cnt++;
        if (!done_seen) done_edge = k;
        done_seen = 1;
      end
      if (done_seen && !busy) break;
      tick();
      k++;
    end
    check("frame.finished",      32'(k < BUDGET),  32'd1);
    check("frame.first_valid",   32'(first_valid), 32'(RD_LAT + 2));
    check("frame.pixel_count",   32'(n_pix),       32'(NUM_WORDS));
    check("frame.bad_pixels",    32'(bad_pix),     32'd0);
    check("frame.last_count",    32'(last_cnt),    32'd1);
    check("frame.last_index",    32'(last_idx),    32'(NUM_WORDS - 1));
    check("frame.done_cycles",   32'(done_cnt),    32'd1);
    check("frame.done_edge",     32'(done_edge),   32'(NUM_WORDS * (RD_LAT + 2)));
    check_idle("frame.end");

    // Back-pressure on word 5 for 10 cycles.
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (k < BUDGET) begin
      pix_ready = (sram_addr != ADDR_W'(5));
      if (pix_valid && sram_addr == ADDR_W'(5)) break;
      tick();
      k++;
    end
    check("stall.reached", 32'(k < BUDGET), 32'd1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pix_data !== 8'd5 || sram_addr !== ADDR_W'(5) || sram_rden !== 1'b0 ||
          pix_valid !== 1'b1)
        bad++;
    end
    check("stall.hold_errors", 32'(bad), 32'd0);
    check("stall.pix_data",    32'(pix_data), 32'd5);

    // Abort during WAIT_RD on word 100, then confirm no done pulse follows.
    wait_state(100, 1'b0, "abort_wait");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("abort.quiet", 32'(bad), 32'd0);

    // A new start reads from address 0 again.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart.sram_addr", 32'(sram_addr), 32'd0);
    check("restart.sram_rden", 32'(sram_rden), 32'd1);
    wait_state(0, 1'b1, "restart_present");
    check("restart.pix_data", 32'(pix_data), 32'd0);

    // Abort together with a handshake: abort wins, no next ISSUE.
    pix_ready = 1'b1;
    abort     = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort_hs");

    // Asynchronous reset in the middle of PRESENT on word 1.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state(1, 1'b1, "areset_present");
    check("areset.pre_data", 32'(pix_data), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_idle("areset");
    check("areset.pix_data", 32'(pix_data), 32'd0);
    check("areset.pix_last", 32'(pix_last), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0 || pix_valid !== 1'b0) bad++;
    end
    check("areset.stays_idle", 32'(bad), 32'd0);

`ifdef SRAM_READER_CHECKSUM_EN
    // Checksum over a frame of all-ones pixels.
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'd1;
    do_reset();
    check("cksum.reset", 32'(checksum), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (k < BUDGET && !done) begin
      tick();
      k++;
    end
    check("cksum.done_seen", 32'(done), 32'd1);
    check("cksum.at_done",   32'(checksum), 32'h0310);
    tick();
    tick();
    check("cksum.held",      32'(checksum), 32'h0310);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
